candy_sram_resp: RTL and testbench

Responder end of the CPU's SRAM read/write interface. It owns the on-chip memory array. It accepts single-cycle write strobes and read requests from the core's fetch and write-back stages. Each read is answered after a fixed, parameterised latency with a one-cycle `rdata_ready` pulse. It sits beside `candy` and serves the ports the core drives: `sram_raddr`, `sram_waddr`, `sram_wdata` and the read/write enables. It returns `sram_rdata` and `rdata_ready`.

---
 rtl/candy_sram_resp_pkg.sv | 17 +
 rtl/candy_sram_array.sv | 43 ++++
 rtl/candy_sram_resp.sv | 75 +++++++
 tb/tb_candy_sram_resp.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candy_sram_resp_pkg.sv
// Shared sizing for the SRAM responder. The core-side defines must agree
// with these values so that both ends of the interface use the same widths.
package candy_sram_resp_pkg;

   localparam int   SRAMAddrWidth = 16;
   localparam int   SRAMDataWidth = 32;
   localparam int   SRAMDepth     = 1024;
   localparam int   SRAMReadLat   = 2;
   localparam logic RstEnable     = 1'b1;

   // Index width of the storage array. The value is never below 1 so that a
   // single-word array still has a legal index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/candy_sram_array.sv
// Storage for the SRAM responder. It has one synchronous write port and one
// combinational read port with write-first bypass and an out-of-range guard.
// It is a separate module so that a foundry macro can replace it.
module candy_sram_array
   import candy_sram_resp_pkg::*;
#(
   parameter int ADDR_W = SRAMAddrWidth,
   parameter int DATA_W = SRAMDataWidth,
   parameter int DEPTH  = SRAMDepth
)(
   input  logic              clk,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              raddr_ok
);

   localparam int              IDX_W = idx_width(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              waddr_ok;
   logic              bypass;

   // The extra leading zero bit lets DEPTH == 2^ADDR_W compare correctly.
   assign waddr_ok = ({1'b0, waddr} < LIMIT);
   assign raddr_ok = ({1'b0, raddr} < LIMIT);
   assign bypass   = write_enable && waddr_ok && (waddr == raddr);

   always_ff @(posedge clk) begin
      if (write_enable && waddr_ok)
         mem[waddr[IDX_W-1:0]] <= wdata;
   end

   always_comb begin
      rdata = '0;
      if (raddr_ok)
         rdata = bypass ? wdata : mem[raddr[IDX_W-1:0]];
   end

endmodule

// File: rtl/candy_sram_resp.sv
// Responder end of the core's SRAM interface. Each accepted read is returned
// READ_LAT cycles later as a one-cycle rdata_ready pulse, in request order.
module candy_sram_resp
   import candy_sram_resp_pkg::*;
#(
   parameter int ADDR_W   = SRAMAddrWidth,
   parameter int DATA_W   = SRAMDataWidth,
   parameter int DEPTH    = SRAMDepth,
   parameter int READ_LAT = SRAMReadLat
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_ready,
   output logic              rdata_err
);

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("candy_sram_resp: READ_LAT must be in 1..4");
   end
   if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("candy_sram_resp: DEPTH must be in 1..2^ADDR_W");
   end

   logic              arr_ok;
   logic [DATA_W-1:0] arr_rdata;

   candy_sram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk          (clk),
      .write_enable (write_enable),
      .waddr        (waddr),
      .wdata        (wdata),
      .raddr        (raddr),
      .rdata        (arr_rdata),
      .raddr_ok     (arr_ok)
   );

   // Stage 0 captures the word when the request is accepted. Later writes
   // therefore cannot disturb a read that is already in flight. Empty stages
   // carry zero data, so the output is 0 whenever no pulse is present.
   logic [READ_LAT-1:0]             vld_pipe;
   logic [READ_LAT-1:0]             err_pipe;
   logic [READ_LAT-1:0][DATA_W-1:0] data_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         vld_pipe  <= '0;
         err_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[0]  <= read_enable;
         err_pipe[0]  <= read_enable & ~arr_ok;
         data_pipe[0] <= read_enable ? arr_rdata : '0;
         for (int i = 1; i < READ_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            err_pipe[i]  <= err_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   assign rdata_ready = vld_pipe[READ_LAT-1];
   assign rdata_err   = err_pipe[READ_LAT-1];
   assign rdata       = data_pipe[READ_LAT-1];

endmodule

// File: tb/tb_candy_sram_resp.sv
// Randomised and directed bench for candy_sram_resp. It keeps a word-array
// reference model and a queue of expected responses with due cycles.
module tb_candy_sram_resp;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int L     = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          write_enable = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0;
   logic          read_enable = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic [DW-1:0] rdata;
   logic          rdata_ready;
   logic          rdata_err;

   candy_sram_resp #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(L)
   ) dut (
      .clk(clk), .rst(rst),
      .write_enable(write_enable), .waddr(waddr), .wdata(wdata),
      .read_enable(read_enable), .raddr(raddr),
      .rdata(rdata), .rdata_ready(rdata_ready), .rdata_err(rdata_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint        due;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   longint        cyc = 0;
   logic [DW-1:0] model [DEPTH];
   exp_t          q [$];

   // Drives one cycle of inputs, applies the memory rules at the edge, and
   // returns what the outputs should show in the cycle after that edge.
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       output logic er, output logic ee, output logic [DW-1:0] ed);
      exp_t e;
      write_enable = we; waddr = wa; wdata = wd; read_enable = re; raddr = ra;
      @(posedge clk);
      cyc++;
      if (we && int'(wa) < DEPTH) model[int'(wa)] = wd;
      if (re) begin
         e.due  = cyc + L - 1;
         e.err  = (int'(ra) >= DEPTH);
         e.data = e.err ? '0 : model[int'(ra)];
         q.push_back(e);
      end
      @(negedge clk);
      er = 1'b0; ee = 1'b0; ed = '0;
      if (q.size() != 0 && q[0].due == cyc) begin
         e  = q.pop_front();
         er = 1'b1; ee = e.err; ed = e.data;
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      return AW'($urandom_range(0, 15));
      else if (r < 9) return AW'($urandom_range(0, DEPTH - 1));
      else            return AW'($urandom_range(DEPTH, 65535));
   endfunction

   task automatic test_reset();
      logic er, ee; logic [DW-1:0] ed;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rdata_ready, rdata_err, rdata} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_value got rdy=%b err=%b data=%h exp all zero", rdata_ready, rdata_err, rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(0, '0, '0, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL idle cyc=%0d got rdy=%b err=%b data=%h exp all zero", cyc, rdata_ready, rdata_err, rdata);
         end
      end
   endtask

   task automatic test_fill();
      logic er, ee; logic [DW-1:0] ed;
      for (int i = 0; i < DEPTH; i++) begin
         step(1, AW'(i), $urandom, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL fill cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
      end
   endtask

   task automatic test_single();
      logic er, ee; logic [DW-1:0] ed;
      int lat = 0, npulse = 0;
      logic [DW-1:0] seen = '0;
      logic          seen_err = 1'b1;
      step(1, AW'(5), 32'hDEADBEEF, 0, '0, er, ee, ed);
      for (int k = 0; k <= L + 1; k++) begin
         if (k == 0) step(0, '0, '0, 1, AW'(5), er, ee, ed);
         else        step(0, '0, '0, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL single cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
         if (rdata_ready) begin
            if (npulse == 0) begin lat = k + 1; seen = rdata; seen_err = rdata_err; end
            npulse++;
         end
      end
      checks++;
      if (npulse !== 1 || lat !== L) begin
         errors++;
         $display("FAIL single_latency got pulses=%0d latency=%0d exp pulses=1 latency=%0d", npulse, lat, L);
      end
      checks++;
      if (seen !== 32'hDEADBEEF || seen_err !== 1'b0) begin
         errors++;
         $display("FAIL single_data got data=%h err=%b exp data=deadbeef err=0", seen, seen_err);
      end
   endtask

   task automatic test_back_to_back();
      logic er, ee; logic [DW-1:0] ed;
      logic [DW-1:0] got [8];
      int npulse = 0, first_k = -1, last_k = -1;
      for (int i = 0; i < 8; i++) step(1, AW'(i), 32'h100 + i, 0, '0, er, ee, ed);
      for (int k = 0; k < 8 + L; k++) begin
         if (k < 8) step(0, '0, '0, 1, AW'(k), er, ee, ed);
         else       step(0, '0, '0, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL b2b cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
         if (rdata_ready) begin
            if (npulse < 8) got[npulse] = rdata;
            if (first_k < 0) first_k = k;
            last_k = k;
            npulse++;
         end
      end
      checks++;
      if (npulse !== 8 || last_k - first_k !== 7) begin
         errors++;
         $display("FAIL b2b_count got pulses=%0d span=%0d exp pulses=8 span=7", npulse, last_k - first_k);
      end
      for (int i = 0; i < 8 && i < npulse; i++) begin
         checks++;
         if (got[i] !== 32'h100 + i) begin
            errors++;
            $display("FAIL b2b_order idx=%0d got data=%h exp data=%h", i, got[i], 32'h100 + i);
         end
      end
   endtask

   task automatic test_collision();
      logic er, ee; logic [DW-1:0] ed;
      logic [DW-1:0] seen [2];
      int npulse = 0;
      for (int k = 0; k < 4 + L; k++) begin
         case (k)
            0:       step(1, AW'(9), 32'h55, 1, AW'(9), er, ee, ed);
            2:       step(0, '0, '0, 1, AW'(9), er, ee, ed);
            3:       step(1, AW'(9), 32'h66, 0, '0, er, ee, ed);
            default: step(0, '0, '0, 0, '0, er, ee, ed);
         endcase
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL collision cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
         if (rdata_ready) begin
            if (npulse < 2) seen[npulse] = rdata;
            npulse++;
         end
      end
      checks++;
      if (npulse !== 2 || seen[0] !== 32'h55 || seen[1] !== 32'h55) begin
         errors++;
         $display("FAIL collision_data got pulses=%0d d0=%h d1=%h exp pulses=2 d0=55 d1=55",
                  npulse, seen[0], seen[1]);
      end
   endtask

   task automatic test_out_of_range();
      logic er, ee; logic [DW-1:0] ed;
      logic [DW-1:0] word0, seen [2];
      logic          serr [2];
      int npulse = 0;
      word0 = model[0];
      for (int k = 0; k < 2 + L; k++) begin
         case (k)
            0:       step(1, AW'(DEPTH), 32'h77, 1, AW'(DEPTH), er, ee, ed);
            1:       step(0, '0, '0, 1, AW'(0), er, ee, ed);
            default: step(0, '0, '0, 0, '0, er, ee, ed);
         endcase
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL oor cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
         if (rdata_ready) begin
            if (npulse < 2) begin seen[npulse] = rdata; serr[npulse] = rdata_err; end
            npulse++;
         end
      end
      checks++;
      if (npulse !== 2 || seen[0] !== '0 || serr[0] !== 1'b1 || seen[1] !== word0 || serr[1] !== 1'b0) begin
         errors++;
         $display("FAIL oor_data got pulses=%0d d0=%h e0=%b d1=%h e1=%b exp pulses=2 d0=0 e0=1 d1=%h e1=0",
                  npulse, seen[0], serr[0], seen[1], serr[1], word0);
      end
   endtask

   task automatic test_reset_mid();
      logic er, ee; logic [DW-1:0] ed;
      logic [DW-1:0] keep;
      int npulse = 0;
      keep = model[20];
      for (int k = 0; k < 3; k++) begin
         step(0, '0, '0, 1, AW'(20 + k), er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL rst_mid_pre cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
      end
      write_enable = 1'b0; read_enable = 1'b0;
      rst = 1'b1;
      q.delete();
      #1;
      checks++;
      if ({rdata_ready, rdata_err, rdata} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL rst_mid_async got rdy=%b err=%b data=%h exp all zero", rdata_ready, rdata_err, rdata);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         if (k == 0) step(0, '0, '0, 1, AW'(20), er, ee, ed);
         else        step(0, '0, '0, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL rst_mid_post cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
         if (rdata_ready) begin
            npulse++;
            checks++;
            if (rdata !== keep) begin
               errors++;
               $display("FAIL rst_mid_keep got data=%h exp data=%h", rdata, keep);
            end
         end
      end
      checks++;
      if (npulse !== 1) begin
         errors++;
         $display("FAIL rst_mid_pulses got pulses=%0d exp pulses=1", npulse);
      end
   endtask

   task automatic test_random();
      logic er, ee; logic [DW-1:0] ed;
      for (int k = 0; k < 3000; k++) begin
         step(1'($urandom_range(0, 1)), pick_addr(), $urandom,
              1'($urandom_range(0, 1)), pick_addr(), er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL random cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
      end
      for (int k = 0; k < L + 1; k++) begin
         step(0, '0, '0, 0, '0, er, ee, ed);
         checks++;
         if ({rdata_ready, rdata_err, rdata} !== {er, ee, ed}) begin
            errors++;
            $display("FAIL random_drain cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                     cyc, rdata_ready, rdata_err, rdata, er, ee, ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_back_to_back();
      test_collision();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
